haze_window_3x3: RTL and testbench



---
 rtl/haze_window_3x3.sv | 93 +++++++++
 tb/tb_haze_window_3x3.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/haze_window_3x3.sv
// haze_window_3x3: streaming RGB 3x3 neighbourhood generator with two line buffers
module haze_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pix_valid,
  input  logic       pix_sof,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [7:0] r1, r2, r3, r4, r5, r6, r7, r8, r9,
  output logic [7:0] g1, g2, g3, g4, g5, g6, g7, g8, g9,
  output logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9,
  output logic       Enable,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [23:0] lb1 [IMG_WIDTH];
  logic [23:0] lb2 [IMG_WIDTH];
  logic [23:0] pix;
  logic [23:0] win [9];
  logic [23:0] win_nxt [9];
  logic [23:0] owin [9];
  logic acc, last, wrap, valid;
  // A sof pixel is always (0,0), which also covers an early restart inside STREAM
  always_comb begin
    pix = {pix_r, pix_g, pix_b};
    acc = pix_valid & (state == STREAM | pix_sof);
    cur_col = pix_sof ? '0 : col;
    cur_row = pix_sof ? '0 : row;
    wrap = cur_col == CW'(IMG_WIDTH - 1);
    last = wrap & (cur_row == RW'(IMG_HEIGHT - 1));
    valid = acc & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
    state_nxt = acc ? (last ? IDLE : STREAM) : state;
    win_nxt = '{win[1], win[2], lb2[cur_col],
                win[4], win[5], lb1[cur_col],
                win[7], win[8], pix};
  end
  // State and raster counters advance only on accepted pixels
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        col <= wrap ? '0 : cur_col + CW'(1);
        row <= last ? '0 : (wrap ? cur_row + RW'(1) : cur_row);
      end
    end
  end
  // Line buffers: read-before-write falls out of the combinational read and clocked write
  always_ff @(posedge clock) begin
    if (acc) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= pix;
    end
  end
  // Column shift registers for the top, middle and current rows
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) win <= '{default: '0};
    else if (acc) win <= win_nxt;
  end
  // Registered window outputs, updated only for complete windows and held otherwise
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owin <= '{default: '0};
      Enable <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      Enable <= valid;
      frame_done <= valid & last;
      if (valid) owin <= win_nxt;
    end
  end
  assign {r1, g1, b1} = owin[0];
  assign {r2, g2, b2} = owin[1];
  assign {r3, g3, b3} = owin[2];
  assign {r4, g4, b4} = owin[3];
  assign {r5, g5, b5} = owin[4];
  assign {r6, g6, b6} = owin[5];
  assign {r7, g7, b7} = owin[6];
  assign {r8, g8, b8} = owin[7];
  assign {r9, g9, b9} = owin[8];
endmodule

// File: tb/tb_haze_window_3x3.sv
// tb_haze_window_3x3: randomized self-checking bench against a frame-image reference model
module tb_haze_window_3x3;
  logic clk = 0, resetn = 0, pv = 0, psof = 0, sel = 0;
  logic [7:0] pr = 0, pg = 0, pb = 0;
  wire [23:0] aw [9];
  wire [23:0] bw [9];
  wire a_en, a_fd, b_en, b_fd;
  logic [215:0] a_w, b_w;
  always #5 clk = ~clk;

  haze_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
    .clock(clk), .resetn(resetn), .pix_valid(pv & !sel), .pix_sof(psof),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .r1(aw[0][23:16]), .r2(aw[1][23:16]), .r3(aw[2][23:16]), .r4(aw[3][23:16]), .r5(aw[4][23:16]),
    .r6(aw[5][23:16]), .r7(aw[6][23:16]), .r8(aw[7][23:16]), .r9(aw[8][23:16]),
    .g1(aw[0][15:8]), .g2(aw[1][15:8]), .g3(aw[2][15:8]), .g4(aw[3][15:8]), .g5(aw[4][15:8]),
    .g6(aw[5][15:8]), .g7(aw[6][15:8]), .g8(aw[7][15:8]), .g9(aw[8][15:8]),
    .b1(aw[0][7:0]), .b2(aw[1][7:0]), .b3(aw[2][7:0]), .b4(aw[3][7:0]), .b5(aw[4][7:0]),
    .b6(aw[5][7:0]), .b7(aw[6][7:0]), .b8(aw[7][7:0]), .b9(aw[8][7:0]),
    .Enable(a_en), .frame_done(a_fd));

  haze_window_3x3 #(.IMG_WIDTH(40), .IMG_HEIGHT(30)) dut_l (
    .clock(clk), .resetn(resetn), .pix_valid(pv & sel), .pix_sof(psof),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .r1(bw[0][23:16]), .r2(bw[1][23:16]), .r3(bw[2][23:16]), .r4(bw[3][23:16]), .r5(bw[4][23:16]),
    .r6(bw[5][23:16]), .r7(bw[6][23:16]), .r8(bw[7][23:16]), .r9(bw[8][23:16]),
    .g1(bw[0][15:8]), .g2(bw[1][15:8]), .g3(bw[2][15:8]), .g4(bw[3][15:8]), .g5(bw[4][15:8]),
    .g6(bw[5][15:8]), .g7(bw[6][15:8]), .g8(bw[7][15:8]), .g9(bw[8][15:8]),
    .b1(bw[0][7:0]), .b2(bw[1][7:0]), .b3(bw[2][7:0]), .b4(bw[3][7:0]), .b5(bw[4][7:0]),
    .b6(bw[5][7:0]), .b7(bw[6][7:0]), .b8(bw[7][7:0]), .b9(bw[8][7:0]),
    .Enable(b_en), .frame_done(b_fd));

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < 9; i++) begin
      a_w[215-24*i -: 24] = aw[i];
      b_w[215-24*i -: 24] = bw[i];
    end
  end

  int tests = 0, fails = 0, n_en = 0, n_fd = 0;
  int mw = 4, mh = 4, m_idx = 0;
  bit m_active = 0;
  logic [23:0] img [64][64];
  logic [215:0] exp_w = '0, obs_w;
  logic exp_en, exp_fd, obs_en, obs_fd;

  function automatic logic [23:0] pixf(int r, int c, int off);
    logic [7:0] v;
    v = 8'(r * 16 + c + off);
    return {v, v + 8'h40, ~v};
  endfunction

  // drive one cycle, predict from the frame image, sample on the following falling edge
  task automatic step(input bit v, input bit s, input logic [23:0] p);
    int r, c;
    pv = v;
    psof = s;
    {pr, pg, pb} = p;
    exp_en = 0;
    exp_fd = 0;
    if (v && resetn && (m_active || s)) begin
      if (s) begin
        m_idx = 0;
        m_active = 1;
      end
      r = m_idx / mw;
      c = m_idx % mw;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        exp_en = 1;
        exp_fd = (m_idx == mw * mh - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_w[215-24*(3*i+j) -: 24] = img[r-2+i][c-2+j];
      end
      m_idx++;
      if (m_idx == mw * mh) begin
        m_active = 0;
        m_idx = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    obs_en = sel ? b_en : a_en;
    obs_fd = sel ? b_fd : a_fd;
    obs_w = sel ? b_w : a_w;
    n_en += int'(obs_en);
    n_fd += int'(obs_fd);
    pv = 0;
    psof = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_en, a_fd, a_w, b_en, b_fd, b_w} !== '0) begin
      fails++;
      $display("FAIL reset_state: small en=%b fd=%b win=%h large en=%b fd=%b, want all 0", a_en, a_fd, a_w, b_en, b_fd);
    end
    resetn = 1;
    step(1, 0, 24'h123456);
    tests++;
    if (obs_en !== 1'b0 || obs_w !== '0) begin
      fails++;
      $display("FAIL idle_drop: en=%b win=%h, want en=0 win=0", obs_en, obs_w);
    end
  endtask

  task automatic test_basic;
    n_en = 0;
    n_fd = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, k == 0, pixf(k / 4, k % 4, 0));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL basic[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
      if (k == 10) begin
        tests++;
        if (obs_en !== 1'b1 || obs_w !== 216'h0040FF_0141FE_0242FD_1050EF_1151EE_1252ED_2060DF_2161DE_2262DD) begin
          fails++;
          $display("FAIL basic_first: en=%b win=%h, want en=1 literal window", obs_en, obs_w);
        end
      end
      if (k == 15) begin
        tests++;
        if (obs_w[23:16] !== 8'h33 || obs_fd !== 1'b1 || obs_en !== 1'b1) begin
          fails++;
          $display("FAIL basic_last: r9=%h fd=%b en=%b, want r9=33 fd=1 en=1", obs_w[23:16], obs_fd, obs_en);
        end
      end
    end
    tests++;
    if (n_en != 4 || n_fd != 1) begin
      fails++;
      $display("FAIL basic_count: enables=%0d frame_done=%0d, want 4 and 1", n_en, n_fd);
    end
  endtask

  task automatic test_gaps;
    int k = 0, cyc = 0;
    bit v;
    n_en = 0;
    n_fd = 0;
    while (k < 16 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      step(v, v && k == 0, pixf(k / 4, k % 4, 0));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL gaps[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", cyc, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
      k += int'(v);
      cyc++;
    end
    repeat (3) begin
      step(0, 0, 24'hABCDEF);
      tests++;
      if (obs_en !== 1'b0 || obs_w !== exp_w) begin
        fails++;
        $display("FAIL gaps_hold: en=%b win=%h, want en=0 win=%h", obs_en, obs_w, exp_w);
      end
    end
    tests++;
    if (k != 16 || n_en != 4 || n_fd != 1) begin
      fails++;
      $display("FAIL gaps_count: pixels=%0d enables=%0d frame_done=%0d, want 16 4 1", k, n_en, n_fd);
    end
  endtask

  task automatic test_back_to_back;
    n_en = 0;
    n_fd = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++) begin
        step(1, k == 0, pixf(k / 4, k % 4, f * 4));
        tests++;
        if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
          fails++;
          $display("FAIL b2b[%0d.%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", f, k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
        end
      end
    tests++;
    if (n_en != 12 || n_fd != 3) begin
      fails++;
      $display("FAIL b2b_count: enables=%0d frame_done=%0d, want 12 and 3", n_en, n_fd);
    end
  endtask

  task automatic test_early_restart;
    n_en = 0;
    n_fd = 0;
    for (int k = 0; k < 9 + 16; k++) begin
      if (k < 9) step(1, k == 0, pixf(k / 4, k % 4, 8'h80));
      else step(1, k == 9, pixf((k - 9) / 4, (k - 9) % 4, 4));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL restart[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
    end
    tests++;
    if (n_en != 4 || n_fd != 1) begin
      fails++;
      $display("FAIL restart_count: enables=%0d frame_done=%0d, want 4 and 1", n_en, n_fd);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 12; k++) begin
      step(1, k == 0, pixf(k / 4, k % 4, 0));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL rstmid_pre[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
    end
    #1 resetn = 0;
    m_active = 0;
    m_idx = 0;
    exp_w = '0;
    #1;
    tests++;
    if ({a_en, a_fd, a_w} !== '0) begin
      fails++;
      $display("FAIL rstmid_async: en=%b fd=%b win=%h, want all 0", a_en, a_fd, a_w);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if ({a_en, a_fd, a_w} !== '0) begin
        fails++;
        $display("FAIL rstmid_hold: en=%b fd=%b win=%h, want all 0", a_en, a_fd, a_w);
      end
    end
    @(negedge clk);
    resetn = 1;
    n_en = 0;
    n_fd = 0;
    for (int k = 0; k < 5 + 16; k++) begin
      if (k < 5) step(1, 0, 24'($urandom));
      else step(1, k == 5, pixf((k - 5) / 4, (k - 5) % 4, 0));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL rstmid_post[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
    end
    tests++;
    if (n_en != 4 || n_fd != 1) begin
      fails++;
      $display("FAIL rstmid_count: enables=%0d frame_done=%0d, want 4 and 1", n_en, n_fd);
    end
  endtask

  task automatic test_large;
    sel = 1;
    mw = 40;
    mh = 30;
    exp_w = '0;
    n_en = 0;
    n_fd = 0;
    for (int k = 0; k < 1200; k++) begin
      step(1, k == 0, 24'($urandom));
      tests++;
      if (obs_en !== exp_en || obs_fd !== exp_fd || obs_w !== exp_w) begin
        fails++;
        $display("FAIL large[%0d]: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", k, obs_en, obs_fd, obs_w, exp_en, exp_fd, exp_w);
      end
    end
    tests++;
    if (n_en != 38 * 28 || n_fd != 1 || obs_fd !== 1'b1) begin
      fails++;
      $display("FAIL large_count: enables=%0d frame_done=%0d last_fd=%b, want 1064 1 1", n_en, n_fd, obs_fd);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_back_to_back;
    test_early_restart;
    test_reset_mid;
    test_large;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
